// File: rtl/smpl_iter.sv
// Sample iterator: walks every subsample position inside a triangle's bounding box, one per cycle.
// Optional serpentine row order is selected by defining SMPL_ITER_SNAKE_EN.
module smpl_iter #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
   input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
   input  logic                                         validTri_R13H,
   input  logic [3:0]                                   subSample_RnnnnU,
   input  logic                                         dsHalt_RnnnnL,
   output logic                                         halt_RnnnnL,
   output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
   output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
   output logic                                         validSamp_R14H
);

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_TEST = 1'b1
   } state_t;

   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;

   state_t              state_r, state_s;
   tri_t                tri_r, tri_s;
   logic [SIGFIG-1:0]   ll_x_r, ll_x_s, ll_y_r, ll_y_s;
   logic [SIGFIG-1:0]   ur_x_r, ur_x_s, ur_y_r, ur_y_s;
   logic [SIGFIG-1:0]   samp_x_r, samp_x_s, samp_y_r, samp_y_s;
   logic                valid_r, valid_s;
   logic [SIGFIG-1:0]   step_s;
   logic [SIGFIG-1:0]   y_next_s;
   logic signed [SIGFIG:0] x_inc_s;
   logic                x_inc_fits_s;
   logic                last_s;
   logic                halt_s;
   logic                accept_s;
`ifdef SMPL_ITER_SNAKE_EN
   logic                dir_r, dir_s;
   logic signed [SIGFIG:0] x_dec_s;
   logic                x_dec_fits_s;
`endif

   // Sign-extend a coordinate by one bit so compares near full scale cannot wrap.
   function automatic logic signed [SIGFIG:0] sext(input logic [SIGFIG-1:0] v);
      return $signed({v[SIGFIG-1], v});
   endfunction

   // Zero-extend the (always positive) step to the compare width.
   function automatic logic signed [SIGFIG:0] zext(input logic [SIGFIG-1:0] v);
      return $signed({1'b0, v});
   endfunction

   // Decode the one-hot subsample selector into a fixed-point step.
   always_comb begin
      step_s = SIGFIG'(1'b1) << RADIX;
      case (subSample_RnnnnU)
         4'b1000: step_s = SIGFIG'(1'b1) << RADIX;
         4'b0100: step_s = SIGFIG'(1'b1) << (RADIX - 1);
         4'b0010: step_s = SIGFIG'(1'b1) << (RADIX - 2);
         4'b0001: step_s = SIGFIG'(1'b1) << (RADIX - 3);
         default: step_s = SIGFIG'(1'b1) << RADIX;
      endcase
   end

   assign x_inc_s      = sext(samp_x_r) + zext(step_s);
   assign x_inc_fits_s = (x_inc_s <= sext(ur_x_r));
   assign y_next_s     = samp_y_r + step_s;

`ifdef SMPL_ITER_SNAKE_EN
   assign x_dec_s      = sext(samp_x_r) - zext(step_s);
   assign x_dec_fits_s = (x_dec_s >= sext(ll_x_r));
   // Odd rows run right-to-left, so the final sample sits at whichever edge the last row ends on.
   assign last_s = (state_r == ST_TEST) && (samp_y_r == ur_y_r) &&
                   (samp_x_r == (dir_r ? ll_x_r : ur_x_r));
`else
   assign last_s = (state_r == ST_TEST) && (samp_y_r == ur_y_r) && (samp_x_r == ur_x_r);
`endif

   // Only dsHalt_RnnnnL reaches halt combinationally; the rest is registered state.
   assign halt_s      = dsHalt_RnnnnL & ((state_r == ST_WAIT) | last_s);
   assign accept_s    = halt_s & validTri_R13H;
   assign halt_RnnnnL = halt_s;

   // Next-state and datapath: accept a new triangle, advance the walk, or retire the last sample.
   always_comb begin
      state_s  = state_r;
      tri_s    = tri_r;
      ll_x_s   = ll_x_r;
      ll_y_s   = ll_y_r;
      ur_x_s   = ur_x_r;
      ur_y_s   = ur_y_r;
      samp_x_s = samp_x_r;
      samp_y_s = samp_y_r;
      valid_s  = valid_r;
`ifdef SMPL_ITER_SNAKE_EN
      dir_s    = dir_r;
`endif
      if (accept_s) begin
         state_s  = ST_TEST;
         tri_s    = tri_R13S;
         ll_x_s   = box_R13S[0][0];
         ll_y_s   = box_R13S[0][1];
         ur_x_s   = box_R13S[1][0];
         ur_y_s   = box_R13S[1][1];
         samp_x_s = box_R13S[0][0];
         samp_y_s = box_R13S[0][1];
         valid_s  = 1'b1;
`ifdef SMPL_ITER_SNAKE_EN
         dir_s    = 1'b0;
`endif
      end else if (dsHalt_RnnnnL && (state_r == ST_TEST)) begin
         if (last_s) begin
            state_s = ST_WAIT;
            valid_s = 1'b0;
         end else begin
`ifdef SMPL_ITER_SNAKE_EN
            if (!dir_r) begin
               if (x_inc_fits_s) begin
                  samp_x_s = x_inc_s[SIGFIG-1:0];
               end else begin
                  samp_y_s = y_next_s;
                  dir_s    = 1'b1;
               end
            end else begin
               if (x_dec_fits_s) begin
                  samp_x_s = x_dec_s[SIGFIG-1:0];
               end else begin
                  samp_y_s = y_next_s;
                  dir_s    = 1'b0;
               end
            end
`else
            if (x_inc_fits_s) begin
               samp_x_s = x_inc_s[SIGFIG-1:0];
            end else begin
               samp_x_s = ll_x_r;
               samp_y_s = y_next_s;
            end
`endif
         end
      end else begin
         state_s = state_r;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_WAIT;
         tri_r    <= '0;
         ll_x_r   <= '0;
         ll_y_r   <= '0;
         ur_x_r   <= '0;
         ur_y_r   <= '0;
         samp_x_r <= '0;
         samp_y_r <= '0;
         valid_r  <= 1'b0;
`ifdef SMPL_ITER_SNAKE_EN
         dir_r    <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         tri_r    <= tri_s;
         ll_x_r   <= ll_x_s;
         ll_y_r   <= ll_y_s;
         ur_x_r   <= ur_x_s;
         ur_y_r   <= ur_y_s;
         samp_x_r <= samp_x_s;
         samp_y_r <= samp_y_s;
         valid_r  <= valid_s;
`ifdef SMPL_ITER_SNAKE_EN
         dir_r    <= dir_s;
`endif
      end
   end

   assign tri_R14S       = tri_r;
   assign sample_R14S    = {samp_y_r, samp_x_r};
   assign validSamp_R14H = valid_r;

endmodule

// File: tb/tb_smpl_iter.sv
// Directed, table-driven bench for smpl_iter: walks, back-to-back, stall and mid-walk reset.
module tb_smpl_iter;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;

   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;

   typedef struct {
      logic       vld;
      logic       ds;
      logic [3:0] ss;
      int         llx, lly, urx, ury;
      int         tid;
      logic       exp_vs;
      int         exp_x, exp_y;
      logic       exp_halt;
      int         exp_tid;
   } vec_t;

   logic clk;
   logic rst;
   logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
   logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
   logic validTri_R13H;
   logic [3:0] subSample_RnnnnU;
   logic dsHalt_RnnnnL;
   logic halt_RnnnnL;
   logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
   logic signed [1:0][SIGFIG-1:0]                 sample_R14S;
   logic validSamp_R14H;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   smpl_iter #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)) dut (
      .clk(clk), .rst(rst),
      .tri_R13S(tri_R13S), .box_R13S(box_R13S),
      .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
      .dsHalt_RnnnnL(dsHalt_RnnnnL), .halt_RnnnnL(halt_RnnnnL),
      .tri_R14S(tri_R14S), .sample_R14S(sample_R14S),
      .validSamp_R14H(validSamp_R14H)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic tri_t make_tri(input int id);
      tri_t t;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            t[v][a] = SIGFIG'(id * 100 + v * 10 + a);
      return t;
   endfunction

   task automatic add(input logic vld, input logic ds, input logic [3:0] ss,
                      input int llx, input int lly, input int urx, input int ury, input int tid,
                      input logic ev, input int ex, input int ey, input logic eh, input int etid);
      vec_t v;
      v.vld = vld; v.ds = ds; v.ss = ss;
      v.llx = llx; v.lly = lly; v.urx = urx; v.ury = ury; v.tid = tid;
      v.exp_vs = ev; v.exp_x = ex; v.exp_y = ey; v.exp_halt = eh; v.exp_tid = etid;
      vecs.push_back(v);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [SIGFIG-1:0] act, input logic [SIGFIG-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_tri(input string name, input tri_t act, input tri_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one record, clock once, then compare the registered outputs.
   task automatic apply(input vec_t v, input string tag);
      validTri_R13H    = v.vld;
      dsHalt_RnnnnL    = v.ds;
      subSample_RnnnnU = v.ss;
      if (v.vld) begin
         box_R13S[0][0] = SIGFIG'(v.llx);
         box_R13S[0][1] = SIGFIG'(v.lly);
         box_R13S[1][0] = SIGFIG'(v.urx);
         box_R13S[1][1] = SIGFIG'(v.ury);
         tri_R13S       = make_tri(v.tid);
      end else begin
         box_R13S[0][0] = SIGFIG'(7168);
         box_R13S[0][1] = SIGFIG'(7168);
         box_R13S[1][0] = SIGFIG'(9216);
         box_R13S[1][1] = SIGFIG'(9216);
         tri_R13S       = make_tri(9);
      end
      @(posedge clk);
      #1;
      check_bit({tag, ".valid"}, validSamp_R14H, v.exp_vs);
      check_bit({tag, ".halt"}, halt_RnnnnL, v.exp_halt);
      if (v.exp_vs) begin
         check_val({tag, ".x"}, sample_R14S[0], SIGFIG'(v.exp_x));
         check_val({tag, ".y"}, sample_R14S[1], SIGFIG'(v.exp_y));
         check_tri({tag, ".tri"}, tri_R14S, make_tri(v.exp_tid));
      end
   endtask

   localparam logic [3:0] SS1 = 4'b1000;
   localparam logic [3:0] SS8 = 4'b0001;

   initial begin
      vec_t h;
      // Basic 3x2 walk at one pixel
      add(1'b1, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1,    0,    0, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 1024,    0, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 2048,    0, 1'b0, 1);
`ifdef SMPL_ITER_SNAKE_EN
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 2048, 1024, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 1024, 1024, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1,    0, 1024, 1'b1, 1);
`else
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1,    0, 1024, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 1024, 1024, 1'b0, 1);
      add(1'b0, 1'b1, SS1, 0, 0, 2048, 1024, 1, 1'b1, 2048, 1024, 1'b1, 1);
`endif
      add(1'b0, 1'b1, SS1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 0);
      // Degenerate box: one sample, halt stays high
      add(1'b1, 1'b1, SS1, 512, 512, 512, 512, 2, 1'b1, 512, 512, 1'b1, 2);
      add(1'b0, 1'b1, SS1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 0);
      // Eighth-pixel step
      add(1'b1, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1,   0,   0, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 128,   0, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 256,   0, 1'b0, 3);
`ifdef SMPL_ITER_SNAKE_EN
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 256, 128, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 128, 128, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1,   0, 128, 1'b1, 3);
`else
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1,   0, 128, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 128, 128, 1'b0, 3);
      add(1'b0, 1'b1, SS8, 0, 0, 256, 128, 3, 1'b1, 256, 128, 1'b1, 3);
`endif
      add(1'b0, 1'b1, SS8, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 0);
      // Back-to-back: A (2x1) then B (1x2) held valid
      add(1'b1, 1'b1, SS1, 0, 0, 1024, 0, 4, 1'b1,    0,    0, 1'b0, 4);
      add(1'b1, 1'b1, SS1, 0, 0, 0, 1024, 5, 1'b1, 1024,    0, 1'b1, 4);
      add(1'b1, 1'b1, SS1, 0, 0, 0, 1024, 5, 1'b1,    0,    0, 1'b0, 5);
      add(1'b0, 1'b1, SS1, 0, 0, 0, 1024, 5, 1'b1,    0, 1024, 1'b1, 5);
      add(1'b0, 1'b1, SS1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 0);
      // Downstream stall during sample 2 of a 6x1 row; a triangle offered mid-stall is ignored
      add(1'b1, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1,    0, 0, 1'b0, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1, 1024, 0, 1'b0, 6);
      add(1'b1, 1'b0, SS1, 0, 0,    0, 0, 7, 1'b1, 1024, 0, 1'b0, 6);
      add(1'b0, 1'b0, SS1, 0, 0, 5120, 0, 6, 1'b1, 1024, 0, 1'b0, 6);
      add(1'b0, 1'b0, SS1, 0, 0, 5120, 0, 6, 1'b1, 1024, 0, 1'b0, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1, 2048, 0, 1'b0, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1, 3072, 0, 1'b0, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1, 4096, 0, 1'b0, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 5120, 0, 6, 1'b1, 5120, 0, 1'b1, 6);
      add(1'b0, 1'b1, SS1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 0);
      add(1'b0, 1'b0, SS1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);

      // Reset state
      rst = 1'b1;
      validTri_R13H = 1'b1;
      dsHalt_RnnnnL = 1'b1;
      subSample_RnnnnU = SS1;
      tri_R13S = make_tri(1);
      box_R13S = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_bit("rst.valid", validSamp_R14H, 1'b0);
      check_val("rst.x", sample_R14S[0], SIGFIG'(0));
      check_val("rst.y", sample_R14S[1], SIGFIG'(0));
      check_tri("rst.tri", tri_R14S, '0);
      check_bit("rst.halt_hi", halt_RnnnnL, 1'b1);
      dsHalt_RnnnnL = 1'b0;
      #1;
      check_bit("rst.halt_lo", halt_RnnnnL, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("v%0d", i));

      // Reset at sample 3 of 6 drops the walk; re-presenting restarts at ll
      h.vld = 1'b1; h.ds = 1'b1; h.ss = SS1;
      h.llx = 0; h.lly = 0; h.urx = 2048; h.ury = 1024; h.tid = 8;
      h.exp_vs = 1'b1; h.exp_x = 0; h.exp_y = 0; h.exp_halt = 1'b0; h.exp_tid = 8;
      apply(h, "mr.s1");
      h.vld = 1'b0; h.exp_x = 1024;
      apply(h, "mr.s2");
      h.exp_x = 2048;
      apply(h, "mr.s3");
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_bit("mr.rst.valid", validSamp_R14H, 1'b0);
      check_bit("mr.rst.halt", halt_RnnnnL, 1'b1);
      check_tri("mr.rst.tri", tri_R14S, '0);
      rst = 1'b0;
      h.vld = 1'b1; h.exp_x = 0;
      apply(h, "mr.r1");
      h.vld = 1'b0; h.exp_x = 1024;
      apply(h, "mr.r2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/smpl_iter.md
# smpl_iter

Sample iterator for the rasterizer pipeline: sits directly downstream of the bounding-box stage and consumes its R13 triangle/box output. For each valid triangle it walks every subsample position inside the bounding box, one sample per cycle, and presents it to the sample-test stage at R14. While a triangle is being walked it back-pressures the bounding-box stage through `halt_RnnnnL`.

## Interface
- `SIGFIG`, 24, bits in fixed-point position/color
- `RADIX`, 10, fraction bits
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex
- `clk` in 1, single clock
- `rst` in 1, synchronous, active-high reset
- `tri_R13S` in `[VERTS][AXIS]xSIGFIG` signed, triangle from the bbox stage
- `box_R13S` in `[2][2]xSIGFIG` signed, `{ll,ur}{x,y}`, corners already aligned to the subsample grid
- `validTri_R13H` in 1, triangle/box valid
- `subSample_RnnnnU` in 4, one-hot sample step: `1000`=1 px, `0100`=1/2, `0010`=1/4, `0001`=1/8
- `dsHalt_RnnnnL` in 1, downstream stall, active-low
- `halt_RnnnnL` out 1, active-low stall to the bbox stage
- `tri_R14S` out `[VERTS][AXIS]xSIGFIG`, latched triangle for the current sample
- `sample_R14S` out `[2]xSIGFIG`, current sample `{x,y}`
- `validSamp_R14H` out 1, sample valid

## Operation
- Step: `step = 1 << (RADIX - ss_w_lg2)`. `ss_w_lg2` is 0/1/2/3 for `1000`/`0100`/`0010`/`0001`, giving 1024/512/256/128 at RADIX=10. `subSample_RnnnnU` is static while the block is not in WAIT.
- The FSM has two states.
  - WAIT: no sample is held.
  - TEST: a sample is held on the outputs.
- `last` is true when `sample_R14S == ur` (raster order).
- Stall output: `halt_RnnnnL = dsHalt_RnnnnL & (state==WAIT | last)`.
- Accept: when `halt_RnnnnL` is high and `validTri_R13H` is high at a clock edge:
  - latch `tri_R13S` and `box_R13S`;
  - load `sample = ll`;
  - set `validSamp_R14H` = 1;
  - next state = TEST.
- Advance: when in TEST, `dsHalt_RnnnnL` is high and the sample is not `last`:
  - if `x + step <= ur_x`, then `x += step`;
  - otherwise `x = ll_x` and `y += step`.
- Finish: when in TEST, `last` is true, `dsHalt_RnnnnL` is high and no triangle is accepted:
  - next state = WAIT;
  - `validSamp_R14H` = 0.
- Downstream stall: when `dsHalt_RnnnnL` is low, all registers hold and `halt_RnnnnL` is low.
- Arithmetic: the compare `x+step` vs `ur_x` (and the same for y) is done at SIGFIG+1 bits signed, so no wrap occurs near the maximum coordinate.
- Sample count per triangle: `((ur_x-ll_x)/step + 1) * ((ur_y-ll_y)/step + 1)`.
- `ll == ur` produces exactly 1 sample.

## Timing
- Reset values:
  - state = WAIT;
  - `validSamp_R14H` = 0;
  - `sample_R14S` = 0;
  - `tri_R14S` = 0;
  - `halt_RnnnnL` = `dsHalt_RnnnnL`.
- Reset mid-walk drops the current triangle with no further samples. The bbox stage retains its triangle because halt was low.
- Latency: a triangle accepted at edge t shows its first sample from t+1. N samples occupy N consecutive cycles when there is no downstream stall.
- Back-to-back: a new triangle is accepted on the edge that retires the last sample, so there is zero bubble between triangles.
- `halt_RnnnnL` has no combinational path from `validTri_R13H`. The only combinational input to it is `dsHalt_RnnnnL`.
- `tri_R14S` is constant across all samples of a triangle.

## Configuration
- `SMPL_ITER_SNAKE_EN` defined: serpentine traversal.
  - Even rows (counted from `ll_y`) go left-to-right.
  - Odd rows go right-to-left, starting at `ur_x` and ending at `ll_x`.
  - At each row end, y steps and x holds.
  - `last` becomes the final position of the final row, which is `ur_x` or `ll_x` depending on row parity.
- `SMPL_ITER_SNAKE_EN` undefined: raster order as specified under Operation.
- Both modes produce the same sample set and count; only the order differs.

## Test plan
- Basic walk, RADIX=10, `1000`, ll=(0,0), ur=(2048,1024), one valid pulse:
  - samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on cycles t+1..t+6;
  - `halt_RnnnnL` is low for t+1..t+5 and high on t+6;
  - `validSamp_R14H` is 0 on t+7.
- Single sample and fine step:
  - ll=ur=(512,512) gives 1 sample and halt never drops.
  - `0001` with ll=(0,0), ur=(256,128) gives 6 samples stepping 128.
- Back-to-back: triangle A is a 2x1 box, triangle B is held valid.
  - B is accepted on the edge that retires A's second sample.
  - B's first sample appears the next cycle.
  - `validSamp_R14H` stays 1 throughout.
- Downstream stall: hold `dsHalt_RnnnnL` low for 3 cycles during sample 2 of 6.
  - Sample 2 is held for 4 cycles.
  - Order is unchanged and `halt_RnnnnL` stays low.
- Reset mid-walk: assert `rst` at sample 3 of 6.
  - Next cycle: `validSamp_R14H`=0, state WAIT, `halt_RnnnnL`=1.
  - Re-presenting the triangle restarts at ll.
- With `SMPL_ITER_SNAKE_EN`, ll=(0,0), ur=(2048,1024), `1000`:
  - order (0,0),(1024,0),(2048,0),(2048,1024),(1024,1024),(0,1024);
  - the last sample is (0,1024).
